// File: rtl/icache_responder_if.sv
// icache_responder_if: fetch-queue and refill-bus signals of the instruction-cache responder.
//   Fetch side : pc_in, cache_rd_en, cache_abort -> dout, dout_valid, busy
//   Memory side: mem_req, mem_addr -> mem_data, mem_valid
//   Statistics : hit_cnt, miss_cnt (hold 0 unless ICACHE_STATS_EN is defined in the design)
// Modports: slave = the cache itself, master = the fetch queue / memory adapter side.
interface icache_responder_if;
    logic [31:0]  pc_in;
    logic         cache_rd_en;
    logic         cache_abort;
    logic [127:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_data;
    logic         mem_valid;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    modport slave (
        input  pc_in, cache_rd_en, cache_abort, mem_data, mem_valid,
        output dout, dout_valid, busy, mem_req, mem_addr, hit_cnt, miss_cnt
    );

    modport master (
        output pc_in, cache_rd_en, cache_abort, mem_data, mem_valid,
        input  dout, dout_valid, busy, mem_req, mem_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped, read-only instruction cache returning whole 128-bit lines.
// A hit answers on the next edge and the cache stays idle, so hits can stream one per cycle.
// A miss refills the line as four 32-bit beats, installs it, then answers from the fill buffer.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - icache_responder_if.slave (fetch request/response, refill bus, statistics)
// Optional feature: define ICACHE_STATS_EN to build the 32-bit hit/miss counters;
// otherwise hit_cnt and miss_cnt are tied to 0.
module icache_responder #(
    parameter int unsigned IDX_W = 4
) (
    input logic              clk,
    input logic              rst,
    icache_responder_if.slave bus
);

    localparam int unsigned TAG_W    = 28 - IDX_W;
    localparam int unsigned NumLines = 1 << IDX_W;

    typedef enum logic [1:0] {StIdle, StRefill, StResp} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              beat_q, beat_d;
    logic [3:0][31:0]        fill_q, fill_d;
    logic                    abort_q, abort_d;
    logic [27:0]             req_line_q, req_line_d;
    logic                    mem_req_q, mem_req_d;
    logic [127:0]            dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic [NumLines-1:0]     valid_q, valid_d;

    // Line storage has no reset; valid_q alone decides whether an entry is usable.
    logic [TAG_W-1:0]        tag_mem_q  [NumLines];
    logic [127:0]            data_mem_q [NumLines];

    logic                    install;
    logic [127:0]            install_line;
    logic                    hit_acc;
    logic                    miss_acc;

    logic [IDX_W-1:0]        lookup_idx;
    logic [TAG_W-1:0]        lookup_tag;
    logic                    lookup_hit;
    logic [IDX_W-1:0]        req_idx;
    logic [TAG_W-1:0]        req_tag;

    // Line-aligned access: the byte offset is not used.
    logic                    unused_pc_offset;
    assign unused_pc_offset = ^bus.pc_in[3:0];

    // Lookup is done combinationally on the live pc_in while idle.
    assign lookup_idx = bus.pc_in[3+IDX_W:4];
    assign lookup_tag = bus.pc_in[31:4+IDX_W];
    assign lookup_hit = valid_q[lookup_idx] && (tag_mem_q[lookup_idx] == lookup_tag);

    assign req_idx = req_line_q[IDX_W-1:0];
    assign req_tag = req_line_q[27:IDX_W];

    // The fourth beat arrives straight from the bus, the first three from the fill buffer.
    assign install_line = {bus.mem_data, fill_q[2], fill_q[1], fill_q[0]};

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        fill_d       = fill_q;
        abort_d      = abort_q;
        req_line_d   = req_line_q;
        mem_req_d    = mem_req_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        valid_d      = valid_q;
        install      = 1'b0;
        hit_acc      = 1'b0;
        miss_acc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                abort_d = 1'b0;
                // A request carrying abort is dropped without a lookup.
                if (bus.cache_rd_en && !bus.cache_abort) begin
                    req_line_d = bus.pc_in[31:4];
                    if (lookup_hit) begin
                        dout_d       = data_mem_q[lookup_idx];
                        dout_valid_d = 1'b1;
                        hit_acc      = 1'b1;
                    end else begin
                        state_d   = StRefill;
                        mem_req_d = 1'b1;
                        beat_d    = 2'd0;
                        miss_acc  = 1'b1;
                    end
                end
            end

            StRefill: begin
                if (bus.cache_abort) begin
                    abort_d = 1'b1;
                end
                if (bus.mem_valid) begin
                    fill_d[beat_q] = bus.mem_data;
                    beat_d         = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        // Install unconditionally, even when the response is cancelled.
                        install          = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        mem_req_d        = 1'b0;
                        beat_d           = 2'd0;
                        if (abort_q || bus.cache_abort) begin
                            state_d = StIdle;
                            abort_d = 1'b0;
                        end else begin
                            state_d = StResp;
                        end
                    end
                end
            end

            StResp: begin
                // Abort here cancels the pulse that would appear on the next cycle.
                if (!bus.cache_abort) begin
                    dout_d       = fill_q;
                    dout_valid_d = 1'b1;
                end
                abort_d = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            beat_q       <= 2'd0;
            fill_q       <= '0;
            abort_q      <= 1'b0;
            req_line_q   <= '0;
            mem_req_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            fill_q       <= fill_d;
            abort_q      <= abort_d;
            req_line_q   <= req_line_d;
            mem_req_q    <= mem_req_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            valid_q      <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            data_mem_q[req_idx] <= install_line;
            tag_mem_q[req_idx]  <= req_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'd0, hit_acc};
        miss_cnt_d = miss_cnt_q + {31'd0, miss_acc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = hit_acc ^ miss_acc;

    assign bus.hit_cnt  = 32'd0;
    assign bus.miss_cnt = 32'd0;
`endif

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = {req_line_q, 4'b0000};

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache responder serving the fetch queue's cache port. Accepts a fetch address plus a read strobe, and returns the full 128-bit line (4 instructions) with a one-cycle valid pulse.
- Direct-mapped, with 2^IDX_W lines.
- On a miss, refills the line from backing memory as 4 x 32-bit beats, installs it, then responds.
- Sits between the fetch queue and the memory/bus adapter.

Parameters:
IDX_W, 4, index bits; number of lines = 2^IDX_W (addr[3+IDX_W:4])
TAG_W, 28-IDX_W, tag bits (addr[31:4+IDX_W]); derived, not overridden

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
pc_in  input  32  fetch byte address; addr[3:0] ignored (line-aligned access)
cache_rd_en  input  1  read request, sampled only in IDLE
cache_abort  input  1  cancel any outstanding/pending response
dout  output  128  line data; word k at bits [32k+31:32k]
dout_valid  output  1  one-cycle pulse, dout valid
busy  output  1  high when state != IDLE; requests ignored
mem_req  output  1  refill request, held high for the whole refill
mem_addr  output  32  {req_addr[31:4],4'b0}, stable while mem_req
mem_data  input  32  refill beat data
mem_valid  input  1  refill beat strobe, one beat per cycle high
hit_cnt  output  32  hits counted (see Optional Feature)
miss_cnt  output  32  misses counted (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - All valid bits are cleared.
  - State goes to IDLE.
  - dout=0, dout_valid=0, mem_req=0, mem_addr=0, busy=0, beat counter=0, abort flag=0, counters=0.
  - Reset mid-refill drops mem_req immediately and discards the partial line.
- States: IDLE, REFILL, RESP.
- IDLE:
  - If cache_rd_en=1 and cache_abort=0: latch pc_in into req_addr and do the lookup combinationally on pc_in.
  - Hit (valid[idx] and tag match): on the next edge, dout <= line and dout_valid <= 1. Stay in IDLE, so back-to-back hits give one response per cycle.
  - Miss: go to REFILL. mem_req=1 from the next cycle.
  - cache_rd_en together with cache_abort: ignored, no lookup, no counter change.
- REFILL:
  - mem_req=1.
  - Each cycle with mem_valid=1 writes mem_data into fill-buffer word[beat], then beat++ (2-bit).
  - On the 4th beat:
    - Write the line, tag and valid[idx]=1.
    - beat <= 0, mem_req drops next cycle.
    - Go to RESP, or to IDLE if the abort flag is set.
  - cache_abort=1 in any REFILL cycle sets the abort flag. The refill still completes and the line is installed, but no response is produced.
- RESP:
  - dout <= installed line and dout_valid=1 for exactly one cycle.
  - Abort flag cleared, return to IDLE.
  - If cache_abort=1 in the cycle the state moves from REFILL to RESP, the response is suppressed (dout_valid stays 0).
- Abort latency rule: cache_abort high in cycle N cancels any response that would appear in N+1 or later. A dout_valid already high in N is not retracted.
- Miss-to-valid latency: 1 (lookup) + memory beats + 1. With beats back-to-back starting the first REFILL cycle, the response appears 6 cycles after the request.
- dout holds its last value while dout_valid=0.
- mem_valid outside REFILL is ignored.
- busy = (state != IDLE), combinational from state.
- Conflict: a refill to an index overwrites the previous line unconditionally (no write-back; read-only cache).

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined: hit_cnt increments on each IDLE hit accepted; miss_cnt increments on each IDLE miss accepted (including later-aborted). Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: counters are not built; hit_cnt and miss_cnt are tied to 0.

Test Plan:
- Cold miss:
  - Stimulus: reset, then rd_en with pc_in=0x0000_0040, mem returns 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Required: mem_addr=0x40 while mem_req; dout_valid one cycle with dout=0x00000044_00000033_00000022_00000011, 6 cycles after the request.
- Hit:
  - Stimulus: rd_en pc_in=0x48, then 0x4C on consecutive cycles.
  - Required: two consecutive dout_valid pulses with the same line, no mem_req, busy=0 throughout.
- Abort mid-refill:
  - Stimulus: miss on 0x100, abort pulsed after beat 2.
  - Required: all 4 beats still consumed, no dout_valid. A later rd_en 0x100 hits with 1-cycle latency.
- Index conflict (IDX_W=4):
  - Stimulus: fill 0x040, then request 0x140.
  - Required: miss and refill. A request to 0x040 misses again.
- Reset mid-refill:
  - Stimulus: rst low after beat 1 of a refill.
  - Required: mem_req=0 immediately; after release, the same address misses.
  - With ICACHE_STATS_EN, the cold-miss and hit sequence gives miss_cnt=1, hit_cnt=2.
- Busy and stray strobes:
  - Stimulus: rd_en asserted during REFILL; mem_valid asserted in IDLE.
  - Required: both ignored, no state or counter change.
